dice_cgra_dispatcher: RTL and testbench

Thread dispatcher feeding the DICE CGRA subsystem: on a block launch it latches the CTA geometry and issues one thread ID per issue slot. For each issued thread it drives the linear TID (`disp_tid`/`disp_valid`) and its x/y/z decomposition. Issue obeys downstream stall and a configurable initiation interval. After the last thread it waits a programmed drain latency, so in-flight CGRA writebacks retire, then pulses `done`.

---
 rtl/dice_cgra_dispatcher_if.sv | 44 ++++
 rtl/dice_cgra_dispatcher.sv | 186 ++++++++++++++++++
 tb/tb_dice_cgra_dispatcher.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/dice_cgra_dispatcher_if.sv
// Launch/dispatch bundle between a launch source (master) and the CGRA thread dispatcher (slave).
interface dice_cgra_dispatcher_if #(
    parameter int NUM_TID      = 512,
    parameter int TID_WIDTH    = $clog2(NUM_TID),
    parameter int MAX_CTA_ID   = 65535,
    parameter int CTA_ID_WIDTH = $clog2(MAX_CTA_ID),
    parameter int MAX_II       = 8,
    parameter int MAX_DRAIN    = 64
);
    localparam int IIW = $clog2(MAX_II + 1);
    localparam int DW  = $clog2(MAX_DRAIN + 1);

    logic                    start;
    logic [TID_WIDTH-1:0]    ntid_x, ntid_y, ntid_z;
    logic [CTA_ID_WIDTH-1:0] ctaid_x, ctaid_y, ctaid_z;
    logic [CTA_ID_WIDTH-1:0] nctaid_x, nctaid_y, nctaid_z;
    logic [IIW-1:0]          ii;
    logic [DW-1:0]           drain_cycles;
    logic                    stall;

    logic [TID_WIDTH-1:0]    disp_tid;
    logic                    disp_valid;
    logic [TID_WIDTH-1:0]    tid_x, tid_y, tid_z;
    logic [TID_WIDTH-1:0]    ntid_x_o, ntid_y_o, ntid_z_o;
    logic [CTA_ID_WIDTH-1:0] ctaid_x_o, ctaid_y_o, ctaid_z_o;
    logic [CTA_ID_WIDTH-1:0] nctaid_x_o, nctaid_y_o, nctaid_z_o;
    logic                    busy, done, err;

    modport master (
        output start, ntid_x, ntid_y, ntid_z, ctaid_x, ctaid_y, ctaid_z,
               nctaid_x, nctaid_y, nctaid_z, ii, drain_cycles, stall,
        input  disp_tid, disp_valid, tid_x, tid_y, tid_z,
               ntid_x_o, ntid_y_o, ntid_z_o, ctaid_x_o, ctaid_y_o, ctaid_z_o,
               nctaid_x_o, nctaid_y_o, nctaid_z_o, busy, done, err
    );

    modport slave (
        input  start, ntid_x, ntid_y, ntid_z, ctaid_x, ctaid_y, ctaid_z,
               nctaid_x, nctaid_y, nctaid_z, ii, drain_cycles, stall,
        output disp_tid, disp_valid, tid_x, tid_y, tid_z,
               ntid_x_o, ntid_y_o, ntid_z_o, ctaid_x_o, ctaid_y_o, ctaid_z_o,
               nctaid_x_o, nctaid_y_o, nctaid_z_o, busy, done, err
    );
endinterface

// File: rtl/dice_cgra_dispatcher.sv
// CTA thread dispatcher: latches block geometry on launch, issues one TID per issue slot
// (honouring stall and initiation interval), then waits out a drain latency before pulsing done.
module dice_cgra_dispatcher #(
    parameter int NUM_TID      = 512,
    parameter int TID_WIDTH    = $clog2(NUM_TID),
    parameter int MAX_CTA_ID   = 65535,
    parameter int CTA_ID_WIDTH = $clog2(MAX_CTA_ID),
    parameter int MAX_II       = 8,
    parameter int MAX_DRAIN    = 64
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  clr,
    dice_cgra_dispatcher_if.slave bus
);
    localparam int TW  = TID_WIDTH;
    localparam int CW  = CTA_ID_WIDTH;
    localparam int IIW = $clog2(MAX_II + 1);
    localparam int DW  = $clog2(MAX_DRAIN + 1);
    localparam int PW  = 3 * TID_WIDTH;
    localparam logic [TW-1:0]  ONE    = 1;
    localparam logic [IIW-1:0] II_ONE = 1;
    localparam logic [DW-1:0]  D_ONE  = 1;
    localparam logic [PW-1:0]  N_MAX  = PW'(NUM_TID);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    state_e             state_q, state_d;
    logic [2:0][TW-1:0] ntid_q, ntid_d;
    logic [2:0][CW-1:0] cta_q, cta_d, ncta_q, ncta_d;
    logic [TW-1:0]      x_q, x_d, y_q, y_d, z_q, z_d, lin_q, lin_d, last_q, last_d;
    logic [TW-1:0]      tid_q, tid_d, tx_q, tx_d, ty_q, ty_d, tz_q, tz_d;
    logic [IIW-1:0]     ii_eff_q, ii_eff_d, ii_cnt_q, ii_cnt_d;
    logic [DW-1:0]      drain_q, drain_d, dcnt_q, dcnt_d;
    logic               vld_q, vld_d, done_q, done_d, err_q, err_d;
    logic [PW-1:0]      n_req;

    // Full-width product so oversized blocks cannot alias into the legal range.
    assign n_req = PW'(bus.ntid_x) * PW'(bus.ntid_y) * PW'(bus.ntid_z);

    always_comb begin
        state_d  = state_q;
        ntid_d   = ntid_q;
        cta_d    = cta_q;
        ncta_d   = ncta_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        lin_d    = lin_q;
        last_d   = last_q;
        tid_d    = tid_q;
        tx_d     = tx_q;
        ty_d     = ty_q;
        tz_d     = tz_q;
        ii_eff_d = ii_eff_q;
        ii_cnt_d = ii_cnt_q;
        drain_d  = drain_q;
        dcnt_d   = dcnt_q;
        vld_d    = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (n_req == '0 || n_req > N_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        ntid_d   = {bus.ntid_z, bus.ntid_y, bus.ntid_x};
                        cta_d    = {bus.ctaid_z, bus.ctaid_y, bus.ctaid_x};
                        ncta_d   = {bus.nctaid_z, bus.nctaid_y, bus.nctaid_x};
                        last_d   = n_req[TW-1:0] - ONE;
                        ii_eff_d = (bus.ii == '0) ? II_ONE : bus.ii;
                        drain_d  = bus.drain_cycles;
                        x_d      = '0;
                        y_d      = '0;
                        z_d      = '0;
                        lin_d    = '0;
                        ii_cnt_d = '0;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (ii_cnt_q == '0 && !bus.stall) begin
                    vld_d    = 1'b1;
                    tid_d    = lin_q;
                    tx_d     = x_q;
                    ty_d     = y_q;
                    tz_d     = z_q;
                    ii_cnt_d = ii_eff_q - II_ONE;
                    lin_d    = lin_q + ONE;
                    if (x_q == ntid_q[0] - ONE) begin
                        x_d = '0;
                        if (y_q == ntid_q[1] - ONE) begin
                            y_d = '0;
                            z_d = z_q + ONE;
                        end else begin
                            y_d = y_q + ONE;
                        end
                    end else begin
                        x_d = x_q + ONE;
                    end
                    if (lin_q == last_q) begin
                        dcnt_d  = drain_q;
                        state_d = DRAIN;
                    end
                end else if (ii_cnt_q != '0) begin
                    ii_cnt_d = ii_cnt_q - II_ONE;
                end
            end
            DRAIN: begin
                if (dcnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    dcnt_d = dcnt_q - D_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q  <= IDLE;
            ntid_q   <= '0;
            cta_q    <= '0;
            ncta_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            lin_q    <= '0;
            last_q   <= '0;
            tid_q    <= '0;
            tx_q     <= '0;
            ty_q     <= '0;
            tz_q     <= '0;
            ii_eff_q <= '0;
            ii_cnt_q <= '0;
            drain_q  <= '0;
            dcnt_q   <= '0;
            vld_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ntid_q   <= ntid_d;
            cta_q    <= cta_d;
            ncta_q   <= ncta_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            lin_q    <= lin_d;
            last_q   <= last_d;
            tid_q    <= tid_d;
            tx_q     <= tx_d;
            ty_q     <= ty_d;
            tz_q     <= tz_d;
            ii_eff_q <= ii_eff_d;
            ii_cnt_q <= ii_cnt_d;
            drain_q  <= drain_d;
            dcnt_q   <= dcnt_d;
            vld_q    <= vld_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.disp_tid   = tid_q;
    assign bus.disp_valid = vld_q;
    assign bus.tid_x      = tx_q;
    assign bus.tid_y      = ty_q;
    assign bus.tid_z      = tz_q;
    assign bus.ntid_x_o   = ntid_q[0];
    assign bus.ntid_y_o   = ntid_q[1];
    assign bus.ntid_z_o   = ntid_q[2];
    assign bus.ctaid_x_o  = cta_q[0];
    assign bus.ctaid_y_o  = cta_q[1];
    assign bus.ctaid_z_o  = cta_q[2];
    assign bus.nctaid_x_o = ncta_q[0];
    assign bus.nctaid_y_o = ncta_q[1];
    assign bus.nctaid_z_o = ncta_q[2];
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_dice_cgra_dispatcher.sv
// Directed bench for dice_cgra_dispatcher. Cycle 0 is the cycle start is driven; cycle c is
// sampled 1 time unit after the c-th following rising edge. Per-cycle input masks drive stall/rst/clr.
module tb_dice_cgra_dispatcher;
    localparam int TW = 9;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst, clr;
    int   n_chk = 0;
    int   n_fail = 0;

    logic          lv[64], ld[64], lb[64], le[64];
    logic [TW-1:0] lt[64], lx[64], ly[64], lz[64], lnx[64];

    dice_cgra_dispatcher_if bus ();
    dice_cgra_dispatcher dut (.clk(clk), .rst(rst), .clr(clr), .bus(bus));

    always #5 clk = ~clk;

    task automatic run(input int nx, input int ny, input int nz, input int iiv, input int drv,
                       input logic [63:0] smask, input logic [63:0] stmask,
                       input logic [63:0] rmask, input logic [63:0] cmask, input int ncyc);
        bus.ntid_x = TW'(nx);
        bus.ntid_y = TW'(ny);
        bus.ntid_z = TW'(nz);
        bus.ii = 4'(iiv);
        bus.drain_cycles = 7'(drv);
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            lv[c] = bus.disp_valid; ld[c] = bus.done; lb[c] = bus.busy; le[c] = bus.err;
            lt[c] = bus.disp_tid; lx[c] = bus.tid_x; ly[c] = bus.tid_y; lz[c] = bus.tid_z;
            lnx[c] = bus.ntid_x_o;
            bus.start = stmask[c];
            bus.stall = smask[c];
            rst = rmask[c];
            clr = cmask[c];
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        rst = 1'b0;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; bus.start = 1'b0; bus.stall = 1'b0;
        bus.ntid_x = '0; bus.ntid_y = '0; bus.ntid_z = '0; bus.ii = '0; bus.drain_cycles = '0;
        bus.ctaid_x = '0; bus.ctaid_y = '0; bus.ctaid_z = '0;
        bus.nctaid_x = '0; bus.nctaid_y = '0; bus.nctaid_z = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_chk++; if (bus.disp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.disp_valid); end
        n_chk++; if (bus.disp_tid !== '0) begin n_fail++; $display("FAIL reset_tid got %0d exp 0", bus.disp_tid); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        n_chk++; if (bus.done !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_done_err got %b%b exp 00", bus.done, bus.err); end
        n_chk++; if (bus.ntid_x_o !== '0 || bus.ctaid_x_o !== '0 || bus.nctaid_z_o !== '0) begin
            n_fail++; $display("FAIL reset_geom got %0d/%0d/%0d exp 0/0/0", bus.ntid_x_o, bus.ctaid_x_o, bus.nctaid_z_o); end
    endtask

    task automatic test_basic();
        logic ev;
        int   t;
        bus.ctaid_x = 16'd5; bus.ctaid_y = 16'd6; bus.ctaid_z = 16'd7;
        bus.nctaid_x = 16'd10; bus.nctaid_y = 16'd11; bus.nctaid_z = 16'd12;
        run(2, 2, 1, 1, 3, 64'h0, 64'h1, 64'h0, 64'h0, 12);
        for (int c = 0; c < 12; c++) begin
            ev = (c >= 2 && c <= 5);
            t = c - 2;
            n_chk++; if (lv[c] !== ev) begin n_fail++; $display("FAIL basic_valid c=%0d got %b exp %b", c, lv[c], ev); end
            if (ev) begin
                n_chk++; if (lt[c] !== TW'(t) || lx[c] !== TW'(t % 2) || ly[c] !== TW'(t / 2) || lz[c] !== '0) begin
                    n_fail++; $display("FAIL basic_tid c=%0d got %0d(%0d,%0d,%0d) exp %0d(%0d,%0d,0)", c, lt[c], lx[c], ly[c], lz[c], t, t % 2, t / 2); end
            end
            n_chk++; if (ld[c] !== (c == 9)) begin n_fail++; $display("FAIL basic_done c=%0d got %b exp %b", c, ld[c], c == 9); end
            n_chk++; if (lb[c] !== (c >= 1 && c <= 8)) begin n_fail++; $display("FAIL basic_busy c=%0d got %b exp %b", c, lb[c], c >= 1 && c <= 8); end
        end
        n_chk++; if (bus.ntid_y_o !== 9'd2 || bus.ctaid_z_o !== 16'd7 || bus.nctaid_x_o !== 16'd10) begin
            n_fail++; $display("FAIL basic_geom got %0d/%0d/%0d exp 2/7/10", bus.ntid_y_o, bus.ctaid_z_o, bus.nctaid_x_o); end
    endtask

    task automatic test_stall();
        logic ev;
        int   t;
        // stall seen at the edges ending cycles 2 and 3 pushes tid1/tid2 out by two cycles
        run(3, 1, 1, 1, 0, 64'hC, 64'h1, 64'h0, 64'h0, 10);
        for (int c = 0; c < 10; c++) begin
            ev = (c == 2 || c == 5 || c == 6);
            t = (c == 2) ? 0 : (c == 5) ? 1 : 2;
            n_chk++; if (lv[c] !== ev) begin n_fail++; $display("FAIL stall_valid c=%0d got %b exp %b", c, lv[c], ev); end
            if (ev) begin
                n_chk++; if (lt[c] !== TW'(t) || lx[c] !== TW'(t)) begin n_fail++; $display("FAIL stall_tid c=%0d got %0d x=%0d exp %0d", c, lt[c], lx[c], t); end
            end
            n_chk++; if (ld[c] !== (c == 7)) begin n_fail++; $display("FAIL stall_done c=%0d got %b exp %b", c, ld[c], c == 7); end
        end
    endtask

    task automatic test_ii();
        logic ev;
        int   t;
        run(2, 1, 2, 3, 1, 64'h0, 64'h1, 64'h0, 64'h0, 16);
        for (int c = 0; c < 16; c++) begin
            ev = (c >= 2 && c <= 11 && (c - 2) % 3 == 0);
            t = (c - 2) / 3;
            n_chk++; if (lv[c] !== ev) begin n_fail++; $display("FAIL ii_valid c=%0d got %b exp %b", c, lv[c], ev); end
            if (ev) begin
                n_chk++; if (lt[c] !== TW'(t) || lx[c] !== TW'(t % 2) || ly[c] !== '0 || lz[c] !== TW'(t / 2)) begin
                    n_fail++; $display("FAIL ii_tid c=%0d got %0d(%0d,%0d,%0d) exp %0d(%0d,0,%0d)", c, lt[c], lx[c], ly[c], lz[c], t, t % 2, t / 2); end
            end
            n_chk++; if (ld[c] !== (c == 13)) begin n_fail++; $display("FAIL ii_done c=%0d got %b exp %b", c, ld[c], c == 13); end
        end
    endtask

    task automatic test_back_to_back();
        logic eb;
        run(1, 1, 1, 1, 0, 64'h0, 64'h9, 64'h0, 64'h0, 9);
        for (int c = 0; c < 9; c++) begin
            eb = (c == 1 || c == 2 || c == 4 || c == 5);
            n_chk++; if (lv[c] !== (c == 2 || c == 5)) begin n_fail++; $display("FAIL b2b_valid c=%0d got %b exp %b", c, lv[c], c == 2 || c == 5); end
            n_chk++; if (ld[c] !== (c == 3 || c == 6)) begin n_fail++; $display("FAIL b2b_done c=%0d got %b exp %b", c, ld[c], c == 3 || c == 6); end
            n_chk++; if (lb[c] !== eb) begin n_fail++; $display("FAIL b2b_busy c=%0d got %b exp %b", c, lb[c], eb); end
        end
        n_chk++; if (lt[5] !== '0) begin n_fail++; $display("FAIL b2b_tid got %0d exp 0", lt[5]); end
    endtask

    task automatic test_err();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) run(0, 4, 4, 1, 0, 64'h0, 64'h1, 64'h0, 64'h0, 5);
            else        run(16, 16, 4, 1, 0, 64'h0, 64'h1, 64'h0, 64'h0, 5);
            for (int c = 0; c < 5; c++) begin
                n_chk++; if (le[c] !== (c == 1)) begin n_fail++; $display("FAIL err_pulse k=%0d c=%0d got %b exp %b", k, c, le[c], c == 1); end
                n_chk++; if (lb[c] !== 1'b0 || lv[c] !== 1'b0) begin n_fail++; $display("FAIL err_busy k=%0d c=%0d got %b%b exp 00", k, c, lb[c], lv[c]); end
            end
            n_chk++; if (bus.ntid_x_o !== 9'd1) begin n_fail++; $display("FAIL err_geom_held k=%0d got %0d exp 1", k, bus.ntid_x_o); end
        end
    endtask

    task automatic test_max_clr();
        // N=512 is the largest legal block; clr aborts it mid-issue
        run(16, 32, 1, 1, 0, 64'h0, 64'h1, 64'h0, 64'h10, 8);
        n_chk++; if (lb[1] !== 1'b1 || le[1] !== 1'b0) begin n_fail++; $display("FAIL max_accept got busy=%b err=%b exp 1,0", lb[1], le[1]); end
        n_chk++; if (lv[4] !== 1'b1 || lt[4] !== 9'd2 || lx[4] !== 9'd2) begin n_fail++; $display("FAIL max_tid got %b/%0d/%0d exp 1/2/2", lv[4], lt[4], lx[4]); end
        n_chk++; if (lv[5] !== 1'b0 || lb[5] !== 1'b0 || lt[5] !== '0 || lnx[5] !== '0) begin
            n_fail++; $display("FAIL clr_state got v=%b b=%b tid=%0d nx=%0d exp 0", lv[5], lb[5], lt[5], lnx[5]); end
        n_chk++; if (ld[6] !== 1'b0 || ld[7] !== 1'b0) begin n_fail++; $display("FAIL clr_done got %b%b exp 00", ld[6], ld[7]); end
    endtask

    task automatic test_reset_midop();
        run(8, 8, 1, 1, 2, 64'h0, 64'h1, 64'h40, 64'h0, 24);
        n_chk++; if (lv[5] !== 1'b1 || lt[5] !== 9'd3) begin n_fail++; $display("FAIL rmid_pre got %b/%0d exp 1/3", lv[5], lt[5]); end
        n_chk++; if (lv[7] !== 1'b0 || lt[7] !== '0 || lx[7] !== '0 || lb[7] !== 1'b0 || le[7] !== 1'b0 || lnx[7] !== '0) begin
            n_fail++; $display("FAIL rmid_clear got v=%b tid=%0d x=%0d b=%b e=%b nx=%0d exp all 0", lv[7], lt[7], lx[7], lb[7], le[7], lnx[7]); end
        for (int c = 7; c < 24; c++) begin
            n_chk++; if (ld[c] !== 1'b0 || lb[c] !== 1'b0) begin n_fail++; $display("FAIL rmid_idle c=%0d got done=%b busy=%b exp 0,0", c, ld[c], lb[c]); end
        end
        run(2, 1, 1, 1, 0, 64'h0, 64'h1, 64'h0, 64'h0, 6);
        n_chk++; if (lv[2] !== 1'b1 || lt[2] !== '0) begin n_fail++; $display("FAIL rmid_restart got %b/%0d exp 1/0", lv[2], lt[2]); end
        n_chk++; if (lv[3] !== 1'b1 || lt[3] !== 9'd1) begin n_fail++; $display("FAIL rmid_second got %b/%0d exp 1/1", lv[3], lt[3]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_ii();
        test_back_to_back();
        test_err();
        test_max_clr();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
